// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage data SRAM-like bus controller:
// FSM state encoding and SRAM-like channel width constants.
package data_sram_ctrl_pkg;

    localparam int STRB_W = 4;
    localparam logic [STRB_W-1:0] FULL_STRB = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/data_sram_ctrl.sv
// MEM-stage data access controller: converts load/store requests into a single
// outstanding SRAM-like transaction and stalls the pipeline until it completes.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [STRB_W-1:0] mem_wsel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    input  logic              stall_other,
    output logic              stall_req,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t              state, state_next;
    logic                discard, discard_next;
    logic                latch_rdata;
    logic                access, issue, in_req;
    logic                wr_q;
    logic [STRB_W-1:0]   strb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    assign access = mem_ren | mem_wen;
    assign issue  = (state == IDLE) & access & ~flush;
    assign in_req = (state == REQ);

    // Zero-cycle issue from live inputs in IDLE; REQ replays the captured copy
    assign data_req   = resetn & (in_req | issue);
    assign data_wr    = in_req ? wr_q    : mem_wen;
    assign data_wstrb = in_req ? strb_q  : (mem_wen ? mem_wsel : FULL_STRB);
    assign data_addr  = in_req ? addr_q  : mem_addr;
    assign data_wdata = in_req ? wdata_q : mem_wdata;

    assign stall_req = resetn & ((access & ~flush & (state != DONE)) | discard);

    always_comb begin
        state_next   = state;
        discard_next = discard;
        latch_rdata  = 1'b0;
        case (state)
            IDLE: begin
                if (issue) state_next = data_addr_ok ? WAIT : REQ;
            end
            REQ: begin
                if (data_addr_ok) begin
                    state_next = WAIT;
                    if (flush) discard_next = 1'b1;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                // An accepted transaction always runs to data_ok; a flush only drops its result
                if (data_data_ok) begin
                    if (discard | flush) begin
                        state_next   = IDLE;
                        discard_next = 1'b0;
                    end else begin
                        state_next  = DONE;
                        latch_rdata = ~wr_q;
                    end
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            DONE: begin
                if (!stall_other) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            discard   <= 1'b0;
            mem_rdata <= '0;
            wr_q      <= 1'b0;
            strb_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
            if (latch_rdata) mem_rdata <= data_rdata;
            if (issue) begin
                wr_q    <= mem_wen;
                strb_q  <= mem_wen ? mem_wsel : FULL_STRB;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed self-checking bench for data_sram_ctrl: load, delayed store,
// flush in REQ and WAIT, completion under external stall, and async reset.
module tb_data_sram_ctrl;
    import data_sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_ren, mem_wen, flush, stall_other;
    logic [3:0]  mem_wsel;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall_req;
    logic [31:0] mem_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wsel(mem_wsel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .stall_other(stall_other),
        .stall_req(stall_req), .mem_rdata(mem_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge so new inputs are applied away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_wsel = 4'h0;
        mem_addr = '0; mem_wdata = '0; flush = 1'b0; stall_other = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

        // Reset: outputs quiet even if a request is presented
        tick();
        mem_ren = 1'b1;
        #2;
        check("rst_req", data_req, 0);
        check("rst_stall", stall_req, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_state", dut.state, IDLE);
        mem_ren = 1'b0;
        tick();
        resetn = 1'b1;

        // Load 0x1000, addr_ok at issue, data_ok next cycle
        tick();
        mem_ren = 1'b1; mem_addr = 32'h1000; data_addr_ok = 1'b1;
        #2;
        check("ld_req", data_req, 1);
        check("ld_wr", data_wr, 0);
        check("ld_wstrb", data_wstrb, 4'hF);
        check("ld_addr", data_addr, 32'h1000);
        check("ld_stall1", stall_req, 1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        #2;
        check("ld_state_wait", dut.state, WAIT);
        check("ld_req_wait", data_req, 0);
        check("ld_stall2", stall_req, 1);
        tick();
        data_data_ok = 1'b0;
        #2;
        check("ld_state_done", dut.state, DONE);
        check("ld_rdata", mem_rdata, 32'hDEADBEEF);
        check("ld_stall_done", stall_req, 0);
        tick();
        mem_ren = 1'b0;
        #2;
        check("ld_state_idle", dut.state, IDLE);

        // Store wsel=0100 to 0x2004, addr_ok only in the fourth request cycle
        tick();
        mem_wen = 1'b1; mem_wsel = 4'b0100; mem_addr = 32'h2004; mem_wdata = 32'h00AB0000;
        #2;
        check("st_req1", data_req, 1);
        check("st_wr1", data_wr, 1);
        check("st_wstrb1", data_wstrb, 4'b0100);
        check("st_addr1", data_addr, 32'h2004);
        tick();
        mem_addr = 32'h3000; mem_wsel = 4'hF; mem_wdata = 32'h0;
        #2;
        check("st_state_req", dut.state, REQ);
        check("st_req2", data_req, 1);
        check("st_addr2", data_addr, 32'h2004);
        check("st_wstrb2", data_wstrb, 4'b0100);
        check("st_wdata2", data_wdata, 32'h00AB0000);
        tick();
        #2;
        check("st_req3", data_req, 1);
        check("st_addr3", data_addr, 32'h2004);
        tick();
        data_addr_ok = 1'b1;
        #2;
        check("st_req4", data_req, 1);
        check("st_wr4", data_wr, 1);
        check("st_wstrb4", data_wstrb, 4'b0100);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55555555;
        #2;
        check("st_req_wait", data_req, 0);
        check("st_stall_wait", stall_req, 1);
        tick();
        data_data_ok = 1'b0; mem_wen = 1'b0;
        #2;
        check("st_state_done", dut.state, DONE);
        check("st_rdata_kept", mem_rdata, 32'hDEADBEEF);
        tick();
        #2;
        check("st_state_idle", dut.state, IDLE);

        // Flush while in REQ before addr_ok: request withdrawn
        tick();
        mem_ren = 1'b1; mem_addr = 32'h4000;
        #2;
        check("fr_req1", data_req, 1);
        tick();
        flush = 1'b1;
        #2;
        check("fr_state_req", dut.state, REQ);
        check("fr_stall_flush", stall_req, 0);
        tick();
        flush = 1'b0; mem_ren = 1'b0;
        #2;
        check("fr_req_drop", data_req, 0);
        check("fr_state_idle", dut.state, IDLE);

        // Flush while in WAIT, data_ok two cycles later: result discarded
        tick();
        mem_ren = 1'b1; mem_addr = 32'h5000; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b1;
        #2;
        check("fw_state_wait", dut.state, WAIT);
        tick();
        flush = 1'b0; mem_ren = 1'b0;
        #2;
        check("fw_stall_discard", stall_req, 1);
        check("fw_state_wait2", dut.state, WAIT);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        #2;
        check("fw_stall_dok", stall_req, 1);
        tick();
        data_data_ok = 1'b0;
        #2;
        check("fw_state_idle", dut.state, IDLE);
        check("fw_rdata_kept", mem_rdata, 32'hDEADBEEF);
        check("fw_stall_clear", stall_req, 0);

        // Load completes while another source holds the pipeline for 3 cycles
        tick();
        stall_other = 1'b1; mem_ren = 1'b1; mem_addr = 32'h6000; data_addr_ok = 1'b1;
        #2;
        check("so_stall_issue", stall_req, 1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
        tick();
        data_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("so_state_done", dut.state, DONE);
            check("so_req_none", data_req, 0);
            check("so_stall", stall_req, 0);
            check("so_rdata", mem_rdata, 32'hCAFEF00D);
            if (i == 2) stall_other = 1'b0;
            tick();
        end
        mem_ren = 1'b0;
        #2;
        check("so_state_idle", dut.state, IDLE);

        // Asynchronous reset in the middle of WAIT
        tick();
        mem_ren = 1'b1; mem_addr = 32'h7000; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #2;
        check("ar_state_wait", dut.state, WAIT);
        resetn = 1'b0;
        #1;
        check("ar_req", data_req, 0);
        check("ar_stall", stall_req, 0);
        check("ar_rdata", mem_rdata, 0);
        check("ar_state", dut.state, IDLE);
        mem_ren = 1'b0;
        tick();
        resetn = 1'b1;

        // Spurious data_ok in IDLE is ignored
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h00000BAD;
        tick();
        data_data_ok = 1'b0;
        #2;
        check("sp_state_idle", dut.state, IDLE);
        check("sp_rdata", mem_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
